// File: rtl/led_pkg.sv
// Shared types and constants for the multi-channel LED counter.
// Build option: define LED_CNT_MULTI_PWM_EN to enable PWM mode.
package led_pkg;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'b00,
      MODE_ON    = 2'b01,
      MODE_BLINK = 2'b10,
      MODE_PWM   = 2'b11
   } mode_t;

   localparam int DUTY_W = 8;

`ifdef LED_CNT_MULTI_PWM_EN
   localparam bit PWM_EN = 1'b1;
`else
   localparam bit PWM_EN = 1'b0;
`endif

   // PWM is the only mode whose legality depends on the build.
   function automatic logic mode_legal(input logic [1:0] mode);
      return PWM_EN || (mode != MODE_PWM);
   endfunction

endpackage

// File: rtl/led_chan.sv
// One LED channel: free-running counter, configuration registers and output decode.
// Build option: LED_CNT_MULTI_PWM_EN adds the duty register and PWM comparator.
module led_chan
   import led_pkg::*;
#(
   parameter int CNT_W   = 27,
   parameter int DIV_W   = 5,
   parameter int DEF_DIV = 0
) (
   input  logic              clk100,
   input  logic              rst,
   input  logic              load,
   input  logic              sync,
   input  logic [1:0]        cfg_mode,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic [DUTY_W-1:0] cfg_duty,
   output logic              led
);

   logic [CNT_W-1:0] cnt;
   mode_t            mode;
   logic [DIV_W-1:0] div;
   logic [DIV_W-1:0] sel;
   logic [CNT_W-1:0] shifted;
   logic             next_led;

`ifdef LED_CNT_MULTI_PWM_EN
   logic [DUTY_W-1:0] duty;
`else
   logic unused_duty;
   assign unused_duty = ^cfg_duty;
`endif

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      next_led = 1'b0;
      // Large dividers clamp to bit 0 rather than indexing below the counter.
      sel      = (div > DIV_W'(CNT_W-1)) ? '0 : DIV_W'(CNT_W-1) - div;
      shifted  = cnt >> sel;
      case (mode)
         MODE_OFF:   next_led = 1'b0;
         MODE_ON:    next_led = 1'b1;
         MODE_BLINK: next_led = shifted[0];
`ifdef LED_CNT_MULTI_PWM_EN
         MODE_PWM:   next_led = DUTY_W'(cnt) < duty;
`endif
         default:    next_led = 1'b0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk100) begin
      if (rst) begin
         cnt  <= '0;
         mode <= MODE_OFF;
         div  <= DIV_W'(DEF_DIV);
         led  <= 1'b0;
`ifdef LED_CNT_MULTI_PWM_EN
         duty <= '0;
`endif
      end else begin
         led <= next_led;
         if (load) begin
            mode <= mode_t'(cfg_mode);
            div  <= cfg_div;
            cnt  <= '0;
`ifdef LED_CNT_MULTI_PWM_EN
            duty <= cfg_duty;
`endif
         end else if (sync) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/led_cnt_multi.sv
// Multi-channel LED driver: write decode, ack/err handshake and NUM_CH led_chan instances.
// Build option: define LED_CNT_MULTI_PWM_EN to enable PWM mode (otherwise PWM writes are rejected).
module led_cnt_multi
   import led_pkg::*;
#(
   parameter int NUM_CH  = 2,
   parameter int CNT_W   = 27,
   parameter int DIV_W   = 5,
   parameter int DEF_DIV = 0
) (
   input  logic                      clk100,
   input  logic                      rst,
   input  logic                      cfg_wren_i,
   input  logic [$clog2(NUM_CH):0]   cfg_ch_i,
   input  logic [1:0]                cfg_mode_i,
   input  logic [DIV_W-1:0]          cfg_div_i,
   input  logic [DUTY_W-1:0]         cfg_duty_i,
   input  logic                      sync_i,
   output logic                      cfg_ack_o,
   output logic                      cfg_err_o,
   output logic [NUM_CH-1:0]         leds_o
);

   localparam int CH_W = $clog2(NUM_CH) + 1;

   logic accept;
   logic reject;
   logic ack_q;
   logic err_q;

   assign accept = cfg_wren_i && (cfg_ch_i < CH_W'(NUM_CH)) && mode_legal(cfg_mode_i);
   assign reject = cfg_wren_i && !accept;

   always_ff @(posedge clk100) begin
      if (rst) begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         ack_q <= accept;
         err_q <= reject;
      end
   end

   // A reset arriving while the response is pending cancels it.
   assign cfg_ack_o = ack_q && !rst;
   assign cfg_err_o = err_q && !rst;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
      led_chan #(
         .CNT_W   (CNT_W),
         .DIV_W   (DIV_W),
         .DEF_DIV (DEF_DIV)
      ) u_chan (
         .clk100   (clk100),
         .rst      (rst),
         .load     (accept && (cfg_ch_i == CH_W'(gi))),
         .sync     (sync_i),
         .cfg_mode (cfg_mode_i),
         .cfg_div  (cfg_div_i),
         .cfg_duty (cfg_duty_i),
         .led      (leds_o[gi])
      );
   end

endmodule

// File: tb/tb_led_cnt_multi.sv
// Self-checking bench for led_cnt_multi (NUM_CH=2, CNT_W=8); honours LED_CNT_MULTI_PWM_EN.
module tb_led_cnt_multi;

   localparam int NUM_CH = 2;
   localparam int CNT_W  = 8;
   localparam int DIV_W  = 5;
`ifdef LED_CNT_MULTI_PWM_EN
   localparam bit PWM_EN = 1'b1;
`else
   localparam bit PWM_EN = 1'b0;
`endif

   logic              clk100 = 1'b0;
   logic              rst = 1'b1;
   logic              wren = 1'b0;
   logic [1:0]        ch = '0;
   logic [1:0]        mode = '0;
   logic [DIV_W-1:0]  div = '0;
   logic [7:0]        duty = '0;
   logic              sync = 1'b0;
   logic              ack;
   logic              err;
   logic [NUM_CH-1:0] leds;

   int checks = 0;
   int failures = 0;

   led_cnt_multi #(
      .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DIV_W(DIV_W), .DEF_DIV(0)
   ) dut (
      .clk100     (clk100),
      .rst        (rst),
      .cfg_wren_i (wren),
      .cfg_ch_i   (ch),
      .cfg_mode_i (mode),
      .cfg_div_i  (div),
      .cfg_duty_i (duty),
      .sync_i     (sync),
      .cfg_ack_o  (ack),
      .cfg_err_o  (err),
      .leds_o     (leds)
   );

   always #5 clk100 = ~clk100;

   // Reference model: per-channel counter and configuration as plain integers.
   int          m_cnt  [NUM_CH];
   int          m_mode [NUM_CH];
   int          m_div  [NUM_CH];
   int          m_duty [NUM_CH];
   logic [NUM_CH-1:0] m_led = '0;
   bit          m_ack = 0;
   bit          m_err = 0;

   function automatic bit led_of(input int i);
      int d;
      case (m_mode[i])
         1: return 1'b1;
         2: begin
            d = (m_div[i] > CNT_W - 1) ? CNT_W - 1 : m_div[i];
            return ((m_cnt[i] / (1 << (CNT_W - 1 - d))) % 2) == 1;
         end
         3: return PWM_EN && ((m_cnt[i] % 256) < m_duty[i]);
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_edge();
      bit acc;
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            m_cnt[i] = 0; m_mode[i] = 0; m_div[i] = 0; m_duty[i] = 0;
         end
         m_led = '0; m_ack = 0; m_err = 0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) m_led[i] = led_of(i);
         acc = wren && (int'(ch) < NUM_CH) && (PWM_EN || int'(mode) != 3);
         for (int i = 0; i < NUM_CH; i++) begin
            if (acc && int'(ch) == i) begin
               m_mode[i] = int'(mode); m_div[i] = int'(div);
               m_duty[i] = int'(duty); m_cnt[i] = 0;
            end else if (sync) begin
               m_cnt[i] = 0;
            end else begin
               m_cnt[i] = (m_cnt[i] + 1) % (1 << CNT_W);
            end
         end
         m_ack = acc;
         m_err = wren && !acc;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk100);
      model_edge();
      #1;
      check("leds_model", 32'(leds), 32'(m_led));
      check("ack_model", 32'(ack), 32'(m_ack && !rst));
      check("err_model", 32'(err), 32'(m_err && !rst));
   endtask

   task automatic write_cfg(input int c, input int md, input int dv, input int dt, input bit sy);
      wren = 1'b1; ch = 2'(c); mode = 2'(md); div = DIV_W'(dv); duty = 8'(dt); sync = sy;
      step();
      wren = 1'b0; sync = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   typedef struct {
      bit      wren;
      int      ch;
      int      mode;
      int      div;
      int      duty;
      bit      sync;
      bit      rst;
      bit      exp_ack;
      bit      exp_err;
   } vec_t;

   vec_t vecs [10];

   initial begin
      // Decode vectors: one cycle each, expected handshake per row.
      vecs[0] = '{1, 0, 1, 0, 0,  0, 0, 1, 0};
      vecs[1] = '{1, 1, 1, 0, 0,  0, 0, 1, 0};
      vecs[2] = '{1, 2, 1, 0, 0,  0, 0, 0, 1};
      vecs[3] = '{1, 3, 2, 3, 0,  0, 0, 0, 1};
      vecs[4] = '{0, 0, 0, 0, 0,  0, 0, 0, 0};
      vecs[5] = '{1, 1, 3, 0, 100, 0, 0, PWM_EN, !PWM_EN};
      vecs[6] = '{1, 0, 0, 0, 0,  0, 1, 0, 0};
      vecs[7] = '{0, 0, 0, 0, 0,  0, 0, 0, 0};
      vecs[8] = '{1, 0, 2, 4, 0,  1, 0, 1, 0};
      vecs[9] = '{1, 1, 0, 0, 0,  0, 0, 1, 0};

      // Reset held for three cycles with a write pending every cycle.
      rst = 1'b1; wren = 1'b1; ch = 2'd0; mode = 2'd1;
      for (int k = 0; k < 3; k++) begin
         step();
         check("rst_leds", 32'(leds), 32'd0);
         check("rst_ack", 32'(ack), 32'd0);
         check("rst_err", 32'(err), 32'd0);
      end
      rst = 1'b0; wren = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step();
         check("ch0_off_after_rst", 32'(leds[0]), 32'd0);
      end

      for (int v = 0; v < 10; v++) begin
         wren = vecs[v].wren; ch = 2'(vecs[v].ch); mode = 2'(vecs[v].mode);
         div = DIV_W'(vecs[v].div); duty = 8'(vecs[v].duty);
         sync = vecs[v].sync; rst = vecs[v].rst;
         step();
         check($sformatf("vec%0d_ack", v), 32'(ack), 32'(vecs[v].exp_ack));
         check($sformatf("vec%0d_err", v), 32'(err), 32'(vecs[v].exp_err));
      end
      wren = 1'b0; sync = 1'b0; rst = 1'b0;
      for (int k = 0; k < 10; k++) step();

      // Blink, div 0 then div 1.
      do_reset();
      write_cfg(0, 2, 0, 0, 0);
      check("blink_ack", 32'(ack), 32'd1);
      for (int c = 0; c < 512; c++) begin
         step();
         check("blink_div0", 32'(leds[0]), 32'((c / 128) % 2));
      end
      write_cfg(0, 2, 1, 0, 0);
      for (int c = 0; c < 256; c++) begin
         step();
         check("blink_div1", 32'(leds[0]), 32'((c / 64) % 2));
      end

      // PWM on channel 1.
      write_cfg(1, 3, 0, 64, 0);
      if (PWM_EN) begin
         check("pwm_ack", 32'(ack), 32'd1);
         for (int c = 0; c < 512; c++) begin
            step();
            check("pwm_duty64", 32'(leds[1]), 32'((c % 256) < 64));
         end
         write_cfg(1, 3, 0, 0, 0);
      end else begin
         check("pwm_err", 32'(err), 32'd1);
         check("pwm_no_ack", 32'(ack), 32'd0);
      end
      for (int c = 0; c < 300; c++) begin
         step();
         check("pwm_zero_or_unchanged", 32'(leds[1]), 32'd0);
      end

      // Out-of-range channel index.
      write_cfg(2, 1, 0, 0, 0);
      check("oor_err", 32'(err), 32'd1);
      check("oor_ack", 32'(ack), 32'd0);
      for (int c = 0; c < 50; c++) begin
         step();
         check("oor_ch1_unchanged", 32'(leds[1]), 32'd0);
      end

      // Sync aligns two offset blink channels.
      write_cfg(0, 2, 5, 0, 0);
      for (int k = 0; k < 3; k++) step();
      write_cfg(1, 2, 5, 0, 0);
      for (int k = 0; k < 5; k++) step();
      sync = 1'b1;
      step();
      sync = 1'b0;
      for (int c = 0; c < 40; c++) begin
         step();
         check("sync_equal", 32'(leds[0]), 32'(leds[1]));
         check("sync_phase", 32'(leds[0]), 32'((c / 4) % 2));
      end
      for (int k = 0; k < 3; k++) step();
      write_cfg(1, 2, 5, 0, 1);
      check("sync_write_ack", 32'(ack), 32'd1);
      for (int c = 0; c < 40; c++) begin
         step();
         check("sync_write_ch1_zero", 32'(leds[1]), 32'((c / 4) % 2));
         check("sync_write_equal", 32'(leds[0]), 32'(leds[1]));
      end

      // Clamp: div 31 selects bit 0, across several wraps.
      write_cfg(0, 2, 31, 0, 0);
      for (int c = 0; c < 600; c++) begin
         step();
         check("clamp_toggle", 32'(leds[0]), 32'(c % 2));
      end

      // Reset in the cycle after a write cancels the pending pulse.
      write_cfg(1, 1, 0, 0, 0);
      check("pend_ack_seen", 32'(ack), 32'd1);
      rst = 1'b1;
      #1;
      check("pend_ack_suppressed", 32'(ack), 32'd0);
      step();
      rst = 1'b0;
      write_cfg(3, 1, 0, 0, 0);
      check("pend_err_seen", 32'(err), 32'd1);
      rst = 1'b1;
      #1;
      check("pend_err_suppressed", 32'(err), 32'd0);
      step();
      rst = 1'b0;

      // Random traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         rst  = ($urandom_range(0, 149) == 0);
         wren = ($urandom_range(0, 3) == 0);
         ch   = 2'($urandom_range(0, 3));
         mode = 2'($urandom_range(0, 3));
         div  = DIV_W'($urandom_range(0, 31));
         duty = 8'($urandom_range(0, 255));
         sync = ($urandom_range(0, 59) == 0);
         step();
         check("no_ack_and_err", 32'(ack && err), 32'd0);
      end
      rst = 1'b0; wren = 1'b0; sync = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/led_cnt_multi.md
LED_CNT_MULTI -- requirements
Module: led_cnt_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of independent LED channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 27: width of each per-channel free-running counter.
REQ-003 SHALL have parameter DIV_W, default 5: width of the divider field; 2**DIV_W >= CNT_W is required.
REQ-004 SHALL have parameter DEF_DIV, default 0: divider value loaded into every channel at reset.
REQ-005 SHALL have port clk100, input, 1: sole clock; one clock, all logic on the rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port cfg_wren_i, input, 1: single-cycle configuration write strobe.
REQ-008 SHALL have port cfg_ch_i, input, $clog2(NUM_CH)+1: target channel index.
REQ-009 SHALL have port cfg_mode_i, input, 2: mode, where 00=OFF, 01=ON, 10=BLINK, 11=PWM.
REQ-010 SHALL have port cfg_div_i, input, DIV_W: blink divider.
REQ-011 SHALL have port cfg_duty_i, input, 8: PWM duty.
REQ-012 SHALL have port sync_i, input, 1: pulse that clears all channel counters.
REQ-013 SHALL have port cfg_ack_o, output, 1: one-cycle pulse on an accepted write.
REQ-014 SHALL have port cfg_err_o, output, 1: one-cycle pulse on a rejected write.
REQ-015 SHALL have port leds_o, output, NUM_CH: registered LED outputs.

Function
REQ-016 SHALL give each channel a CNT_W-bit counter that increments by 1 per cycle and wraps from all-ones to 0 with no flag.
REQ-017 SHALL drive leds_o[i] in OFF mode as 0 and in ON mode as 1.
REQ-018 SHALL drive leds_o[i] in BLINK mode as cnt[CNT_W-1-div]; a div greater than CNT_W-1 is clamped to CNT_W-1 (bit 0).
REQ-019 SHALL drive leds_o[i] in PWM mode as (cnt[7:0] < duty): duty 0 gives a constant 0; duty 255 gives 255/256 high.
REQ-020 SHALL register leds_o so that leds_o in cycle t+1 reflects the counter and configuration in cycle t.
REQ-021 SHALL treat a write as accepted when cfg_wren_i=1 and cfg_ch_i<NUM_CH (and the mode is legal per REQ-033): on that edge, load the channel's mode, div and duty, clear its counter to 0, and pulse cfg_ack_o in the following cycle.
REQ-022 SHALL reject a write whose cfg_ch_i>=NUM_CH: no state changes and cfg_err_o pulses in the following cycle.
REQ-023 SHALL ensure cfg_ack_o and cfg_err_o are never both high; back-to-back writes on consecutive cycles are each acknowledged.
REQ-024 SHALL, when sync_i=1, clear all counters to 0 on that edge; a write in the same cycle still loads its configuration, and its channel's counter is 0.
REQ-025 SHALL let channels not addressed by a write keep their counter and configuration unchanged.

Reset
REQ-026 SHALL, on rst=1, set all counters to 0, all modes to OFF, div to DEF_DIV, duty to 0, and leds_o, cfg_ack_o and cfg_err_o to 0 at the next edge.
REQ-027 SHALL give rst priority over cfg_wren_i and sync_i in the same cycle: the write is lost and neither ack nor err is produced.
REQ-028 SHALL, if rst is asserted in the cycle after a write, suppress the pending ack/err pulse.

Configuration
REQ-029 SHALL support a macro LED_CNT_MULTI_PWM_EN.
REQ-030 SHALL, when LED_CNT_MULTI_PWM_EN is defined, implement PWM mode per REQ-019.
REQ-031 SHALL, when LED_CNT_MULTI_PWM_EN is undefined, include no duty registers or comparator.
REQ-032 SHALL, when LED_CNT_MULTI_PWM_EN is undefined, ignore cfg_duty_i.
REQ-033 SHALL, when LED_CNT_MULTI_PWM_EN is undefined, reject a write with cfg_mode_i=11 as in REQ-022 (err pulse, no state change).

Structure
REQ-034 SHALL place the mode enum (OFF/ON/BLINK/PWM) and the duty width constant in package led_pkg.
REQ-035 SHALL use one per-channel sub-module, led_chan, holding the counter, configuration registers and output decode, instantiated NUM_CH times in a generate loop.
REQ-036 SHALL keep the write-decode and ack/err logic in led_cnt_multi.

Verification (NUM_CH=2, CNT_W=8, DEF_DIV=0)
REQ-037 SHALL verify reset with held writes: assert rst for 3 cycles while cfg_wren_i=1 -> leds_o=00, no ack/err, and channel 0 OFF after release.
REQ-038 SHALL verify blink: write ch0 BLINK div=0 -> ack 1 cycle later; leds_o[0] low for 128 cycles, then high for 128 cycles, repeating; write ch0 div=1 -> period 128.
REQ-039 SHALL verify PWM: write ch1 PWM duty=64 -> leds_o[1] high for 64 of every 256 cycles; duty=0 -> constant 0; without the macro, the same write -> cfg_err_o pulse and ch1 unchanged.
REQ-040 SHALL verify out-of-range writes: write cfg_ch_i=2 -> cfg_err_o pulse, no ack, both channels unchanged.
REQ-041 SHALL verify sync: ch0 and ch1 BLINK with offset phases, pulse sync_i -> both outputs identical from then on; a write to ch1 in the same cycle as sync_i -> ack and ch1 counter 0.
REQ-042 SHALL verify wrap and clamp: BLINK div=31 -> leds_o[0] toggles every cycle (cnt[0]); the counter wraps 255->0 with no glitch on leds_o.
